// File: rtl/score_pkg.sv
// Shared types and 7-segment constants for the score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StHold,
    StRestart,
    StDone
  } state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Round-result inputs and match status outputs of the score keeper.
interface score_keeper_if;
  logic       win_left;
  logic       win_right;
  logic       freeze;
  logic       round_restart;
  logic       match_over;
  logic [6:0] hex_left;
  logic [6:0] hex_right;

  // Upstream playfield / display side
  modport master (
    output win_left, win_right,
    input  freeze, round_restart, match_over, hex_left, hex_right
  );

  // Score keeper side
  modport slave (
    input  win_left, win_right,
    output freeze, round_restart, match_over, hex_left, hex_right
  );
endinterface

// File: rtl/score_hex.sv
// 4-bit value to active-low 7-segment decoder; blank above 9.
module score_hex
  import score_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Pure lookup, no state
  always_comb begin
    seg_o = seg_decode(value_i);
  end

endmodule

// File: rtl/score_keeper.sv
// Match-level score keeper: counts round wins, freezes play between rounds,
// pulses a playfield restart and flags the end of the match.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MaxScore   = 7,
  parameter int unsigned HoldCycles = 50_000_000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  score_keeper_if.slave bus_io
);

  localparam int unsigned ScoreW = $clog2(MaxScore + 1);
  localparam int unsigned CntW   = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  localparam logic [ScoreW-1:0] ScoreMax = ScoreW'(MaxScore);
  localparam logic [CntW-1:0]   CntLast  = CntW'(HoldCycles - 1);

  state_e            state_q;
  logic [ScoreW-1:0] score_left_q;
  logic [ScoreW-1:0] score_right_q;
  logic [CntW-1:0]   cnt_q;
  logic              freeze_q;
  logic              restart_q;
  logic              over_q;

  // Round FSM with score, hold counter and registered Moore outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StPlay;
      score_left_q  <= '0;
      score_right_q <= '0;
      cnt_q         <= '0;
      freeze_q      <= 1'b0;
      restart_q     <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          // A tie (both pulses together) scores nothing but still ends the round
          if (bus_io.win_left && !bus_io.win_right && score_left_q != ScoreMax) begin
            score_left_q <= score_left_q + 1'b1;
          end
          if (bus_io.win_right && !bus_io.win_left && score_right_q != ScoreMax) begin
            score_right_q <= score_right_q + 1'b1;
          end
          if (bus_io.win_left || bus_io.win_right) begin
            state_q  <= StHold;
            cnt_q    <= '0;
            freeze_q <= 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == CntLast) begin
            if (score_left_q == ScoreMax || score_right_q == ScoreMax) begin
              state_q <= StDone;
              over_q  <= 1'b1;
            end else begin
              state_q   <= StRestart;
              restart_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRestart: begin
          state_q   <= StPlay;
          restart_q <= 1'b0;
          freeze_q  <= 1'b0;
        end
        StDone: begin
          state_q <= StDone;
        end
      endcase
    end
  end

  assign bus_io.freeze        = freeze_q;
  assign bus_io.round_restart = restart_q;
  assign bus_io.match_over    = over_q;

  score_hex u_hex_left (
    .value_i (4'(score_left_q)),
    .seg_o   (bus_io.hex_left)
  );

  score_hex u_hex_right (
    .value_i (4'(score_right_q)),
    .seg_o   (bus_io.hex_right)
  );

endmodule
